// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one L2/memory port between icache and dcache.
package xentry_pkg;
  typedef enum logic [1:0] {MEM_LOAD, MEM_STORE} memory_operation_e;
endpackage

module mem_arbiter
  import xentry_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      ic_req_address,
  input  memory_operation_e    ic_req_type,
  input  logic                 ic_req_valid,
  input  logic [XLEN-1:0]      ic_word_to_store,
  output logic [XLEN-1:0]      ic_fetched_word,
  output logic                 ic_req_fulfilled,
  input  logic [XLEN-1:0]      dc_req_address,
  input  memory_operation_e    dc_req_type,
  input  logic                 dc_req_valid,
  input  logic [XLEN-1:0]      dc_word_to_store,
  output logic [XLEN-1:0]      dc_fetched_word,
  output logic                 dc_req_fulfilled,
  output logic [XLEN-1:0]      mem_req_address,
  output memory_operation_e    mem_req_type,
  output logic                 mem_req_valid,
  output logic [XLEN-1:0]      mem_word_to_store,
  input  logic [XLEN-1:0]      mem_fetched_word,
  input  logic                 mem_req_fulfilled,
  output logic [CNT_WIDTH-1:0] ic_grant_count,
  output logic [CNT_WIDTH-1:0] dc_grant_count
);
  typedef enum logic [1:0] {IDLE, SERVE_IC, SERVE_DC, RESPOND} state_e;
  state_e state_q, state_d;
  logic last_dc_q, last_dc_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, ic_word_q, ic_word_d, dc_word_q, dc_word_d;
  memory_operation_e type_q, type_d;
  logic [CNT_WIDTH-1:0] ic_cnt_q, ic_cnt_d, dc_cnt_q, dc_cnt_d;
  logic pick_ic, pick_dc;
  // last_dc_q doubles as the identity of the client being served until RESPOND ends
  assign pick_ic = ic_req_valid && (!dc_req_valid || last_dc_q);
  assign pick_dc = dc_req_valid && (!ic_req_valid || !last_dc_q);
  always_comb begin
    state_d   = state_q;
    last_dc_d = last_dc_q;
    addr_d    = addr_q;
    type_d    = type_q;
    wdata_d   = wdata_q;
    ic_word_d = ic_word_q;
    dc_word_d = dc_word_q;
    ic_cnt_d  = ic_cnt_q;
    dc_cnt_d  = dc_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_ic) begin
          state_d   = SERVE_IC;
          last_dc_d = 1'b0;
          addr_d    = ic_req_address;
          type_d    = ic_req_type;
          wdata_d   = ic_word_to_store;
          ic_cnt_d  = (ic_cnt_q == '1) ? ic_cnt_q : ic_cnt_q + CNT_WIDTH'(1);
        end else if (pick_dc) begin
          state_d   = SERVE_DC;
          last_dc_d = 1'b1;
          addr_d    = dc_req_address;
          type_d    = dc_req_type;
          wdata_d   = dc_word_to_store;
          dc_cnt_d  = (dc_cnt_q == '1) ? dc_cnt_q : dc_cnt_q + CNT_WIDTH'(1);
        end
      end
      SERVE_IC: begin
        ic_word_d = mem_req_fulfilled ? mem_fetched_word : ic_word_q;
        state_d   = mem_req_fulfilled ? RESPOND : SERVE_IC;
      end
      SERVE_DC: begin
        dc_word_d = mem_req_fulfilled ? mem_fetched_word : dc_word_q;
        state_d   = mem_req_fulfilled ? RESPOND : SERVE_DC;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_dc_q <= 1'b1;
      addr_q    <= '0;
      type_q    <= MEM_LOAD;
      wdata_q   <= '0;
      ic_word_q <= '0;
      dc_word_q <= '0;
      ic_cnt_q  <= '0;
      dc_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_dc_q <= last_dc_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      wdata_q   <= wdata_d;
      ic_word_q <= ic_word_d;
      dc_word_q <= dc_word_d;
      ic_cnt_q  <= ic_cnt_d;
      dc_cnt_q  <= dc_cnt_d;
    end
  end
  assign mem_req_valid     = (state_q == SERVE_IC) || (state_q == SERVE_DC);
  assign mem_req_address   = addr_q;
  assign mem_req_type      = type_q;
  assign mem_word_to_store = wdata_q;
  assign ic_req_fulfilled  = (state_q == RESPOND) && !last_dc_q;
  assign dc_req_fulfilled  = (state_q == RESPOND) && last_dc_q;
  assign ic_fetched_word   = ic_word_q;
  assign dc_fetched_word   = dc_word_q;
  assign ic_grant_count    = ic_cnt_q;
  assign dc_grant_count    = dc_cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions plus directed corner sequences for mem_arbiter.
module tb_mem_arbiter;
  import xentry_pkg::*;
  logic clk = 0, reset = 0;
  logic [31:0] ic_req_address = 0, ic_word_to_store = 0, ic_fetched_word;
  logic [31:0] dc_req_address = 0, dc_word_to_store = 0, dc_fetched_word;
  memory_operation_e ic_req_type = MEM_LOAD, dc_req_type = MEM_LOAD, mem_req_type, mem_req_type2;
  logic ic_req_valid = 0, dc_req_valid = 0, ic_req_fulfilled, dc_req_fulfilled;
  logic [31:0] mem_req_address, mem_word_to_store, mem_fetched_word = 0;
  logic mem_req_valid, mem_req_fulfilled = 0;
  logic [15:0] ic_grant_count, dc_grant_count;
  logic [31:0] ic_fw2, dc_fw2, mra2, mws2;
  logic icf2, dcf2, mrv2;
  logic [1:0] ic_cnt2, dc_cnt2;
  int errors = 0, checks = 0;
  logic [31:0] exp_icw, exp_dcw;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_address(ic_req_address), .ic_req_type(ic_req_type), .ic_req_valid(ic_req_valid),
    .ic_word_to_store(ic_word_to_store), .ic_fetched_word(ic_fetched_word), .ic_req_fulfilled(ic_req_fulfilled),
    .dc_req_address(dc_req_address), .dc_req_type(dc_req_type), .dc_req_valid(dc_req_valid),
    .dc_word_to_store(dc_word_to_store), .dc_fetched_word(dc_fetched_word), .dc_req_fulfilled(dc_req_fulfilled),
    .mem_req_address(mem_req_address), .mem_req_type(mem_req_type), .mem_req_valid(mem_req_valid),
    .mem_word_to_store(mem_word_to_store), .mem_fetched_word(mem_fetched_word), .mem_req_fulfilled(mem_req_fulfilled),
    .ic_grant_count(ic_grant_count), .dc_grant_count(dc_grant_count)
  );

  mem_arbiter #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .ic_req_address(ic_req_address), .ic_req_type(ic_req_type), .ic_req_valid(ic_req_valid),
    .ic_word_to_store(ic_word_to_store), .ic_fetched_word(ic_fw2), .ic_req_fulfilled(icf2),
    .dc_req_address(dc_req_address), .dc_req_type(dc_req_type), .dc_req_valid(dc_req_valid),
    .dc_word_to_store(dc_word_to_store), .dc_fetched_word(dc_fw2), .dc_req_fulfilled(dcf2),
    .mem_req_address(mra2), .mem_req_type(mem_req_type2), .mem_req_valid(mrv2),
    .mem_word_to_store(mws2), .mem_fetched_word(mem_fetched_word), .mem_req_fulfilled(mem_req_fulfilled),
    .ic_grant_count(ic_cnt2), .dc_grant_count(dc_cnt2)
  );

  typedef struct {
    logic rst, ic_v, dc_v;
    logic [31:0] ic_a, ic_w, dc_a;
    memory_operation_e dc_t;
    logic [31:0] dc_w;
    int wait_n;
    logic [31:0] rdata;
    logic exp_dc;
    logic [15:0] exp_ic_cnt, exp_dc_cnt;
  } txn_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic do_reset();
    ic_req_valid = 0;
    dc_req_valid = 0;
    mem_req_fulfilled = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    exp_icw = 0;
    exp_dcw = 0;
  endtask

  task automatic run(input txn_t t);
    logic [31:0] ea, ew;
    memory_operation_e et;
    if (t.rst) do_reset();
    ic_req_valid = t.ic_v; dc_req_valid = t.dc_v;
    ic_req_address = t.ic_a; ic_word_to_store = t.ic_w; ic_req_type = MEM_LOAD;
    dc_req_address = t.dc_a; dc_word_to_store = t.dc_w; dc_req_type = t.dc_t;
    ea = t.exp_dc ? t.dc_a : t.ic_a;
    ew = t.exp_dc ? t.dc_w : t.ic_w;
    et = t.exp_dc ? t.dc_t : MEM_LOAD;
    tick();
    for (int c = 0; c <= t.wait_n; c++) begin
      chk("serve_valid", mem_req_valid, 1);
      chk("serve_addr", mem_req_address, ea);
      chk("serve_type", mem_req_type, et);
      chk("serve_wdata", mem_word_to_store, ew);
      chk("serve_no_fulfill", {ic_req_fulfilled, dc_req_fulfilled}, 0);
      ic_req_address = ~ic_req_address;
      dc_req_address = ~dc_req_address;
      dc_word_to_store = ~dc_word_to_store;
      if (c < t.wait_n) tick();
    end
    mem_fetched_word = t.rdata;
    mem_req_fulfilled = 1;
    tick();
    mem_req_fulfilled = 0;
    if (t.exp_dc) exp_dcw = t.rdata; else exp_icw = t.rdata;
    chk("resp_ic_fulfilled", ic_req_fulfilled, !t.exp_dc);
    chk("resp_dc_fulfilled", dc_req_fulfilled, t.exp_dc);
    chk("resp_mem_valid", mem_req_valid, 0);
    chk("resp_ic_word", ic_fetched_word, exp_icw);
    chk("resp_dc_word", dc_fetched_word, exp_dcw);
    tick();
    chk("idle_fulfilled", {ic_req_fulfilled, dc_req_fulfilled}, 0);
    chk("ic_count", ic_grant_count, t.exp_ic_cnt);
    chk("dc_count", dc_grant_count, t.exp_dc_cnt);
  endtask

  txn_t tbl[6];

  initial begin
    tbl[0] = '{1, 0, 1, 32'h0,    32'h0,         32'h0000_1040, MEM_LOAD,  32'h0,         3, 32'hDEAD_BEEF, 1, 0, 1};
    tbl[1] = '{1, 1, 1, 32'h2000, 32'hA5A5_0001, 32'h3000,      MEM_LOAD,  32'h0,         1, 32'h1111_2222, 0, 1, 0};
    tbl[2] = '{0, 1, 1, 32'h2004, 32'hA5A5_0002, 32'h3004,      MEM_LOAD,  32'h0,         0, 32'h3333_4444, 1, 1, 1};
    tbl[3] = '{0, 1, 1, 32'h2008, 32'h0,         32'h3008,      MEM_LOAD,  32'h0,         2, 32'h5555_6666, 0, 2, 1};
    tbl[4] = '{0, 0, 1, 32'h0,    32'h0,         32'h0000_0200, MEM_STORE, 32'h1234_5678, 2, 32'h0,         1, 2, 2};
    tbl[5] = '{0, 1, 0, 32'h44,   32'h0,         32'h0,         MEM_LOAD,  32'h0,         0, 32'h0BAD_F00D, 0, 3, 2};

    do_reset();
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_fulfilled", {ic_req_fulfilled, dc_req_fulfilled}, 0);
    chk("rst_data", {mem_req_address, mem_word_to_store}, 0);
    chk("rst_type", mem_req_type, MEM_LOAD);
    chk("rst_words", {ic_fetched_word, dc_fetched_word}, 0);
    chk("rst_counts", {ic_grant_count, dc_grant_count, ic_cnt2, dc_cnt2}, 0);

    mem_req_fulfilled = 1;
    mem_fetched_word = 32'hFFFF_FFFF;
    tick();
    mem_req_fulfilled = 0;
    chk("idle_strobe_valid", mem_req_valid, 0);
    chk("idle_strobe_fulfilled", {ic_req_fulfilled, dc_req_fulfilled}, 0);
    tick();
    chk("idle_strobe_words", {ic_fetched_word, dc_fetched_word}, 0);

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // reset during SERVE_IC abandons the transaction
    ic_req_valid = 1;
    ic_req_address = 32'h900;
    dc_req_valid = 0;
    tick();
    chk("abort_serving", mem_req_valid, 1);
    reset = 1;
    ic_req_valid = 0;
    tick();
    reset = 0;
    mem_req_fulfilled = 1;
    chk("abort_valid", mem_req_valid, 0);
    chk("abort_no_pulse", ic_req_fulfilled, 0);
    chk("abort_counts", {ic_grant_count, dc_grant_count}, 0);
    tick();
    mem_req_fulfilled = 0;
    chk("abort_late_strobe", {ic_req_fulfilled, dc_req_fulfilled, mem_req_valid}, 0);
    tick();
    chk("abort_after", {ic_req_fulfilled, dc_req_fulfilled, mem_req_valid}, 0);
    chk("abort_words", {ic_fetched_word, dc_fetched_word}, 0);

    // dc drops valid while being served
    dc_req_valid = 1;
    dc_req_address = 32'h500;
    tick();
    chk("drop_serving", mem_req_valid, 1);
    dc_req_valid = 0;
    tick();
    chk("drop_still_serving", mem_req_valid, 1);
    mem_fetched_word = 32'h77;
    mem_req_fulfilled = 1;
    tick();
    mem_req_fulfilled = 0;
    chk("drop_pulse", {ic_req_fulfilled, dc_req_fulfilled}, 2'b01);
    chk("drop_word", dc_fetched_word, 32'h77);
    tick();
    chk("drop_pulse_end", {ic_req_fulfilled, dc_req_fulfilled, mem_req_valid}, 0);
    tick();
    chk("drop_no_repeat", {ic_req_fulfilled, dc_req_fulfilled, mem_req_valid}, 0);

    // five dc grants: narrow counter saturates
    do_reset();
    dc_req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_req_fulfilled = 1;
      tick();
      mem_req_fulfilled = 0;
      tick();
    end
    dc_req_valid = 0;
    tick();
    chk("sat_wide", dc_grant_count, 5);
    chk("sat_narrow", dc_cnt2, 3);
    chk("sat_narrow_ic", ic_cnt2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (ic_req_fulfilled && dc_req_fulfilled) begin
      errors++;
      $display("FAIL both_fulfilled: got 1 expected 0");
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each grant statistics counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ic_req_address  input  XLEN  icache miss/fill address.
REQ-007 ic_req_type  input  memory_operation_e  icache operation type (xentry_pkg).
REQ-008 ic_req_valid  input  1  icache request pending.
REQ-009 ic_word_to_store  input  XLEN  icache store data (normally unused).
REQ-010 ic_fetched_word  output  XLEN  response word to icache.
REQ-011 ic_req_fulfilled  output  1  one-cycle completion pulse to icache.
REQ-012 dc_req_address, dc_req_type, dc_req_valid, dc_word_to_store, dc_fetched_word, dc_req_fulfilled SHALL have the same directions, widths and meanings as the ic_ ports, and SHALL connect to the dcache l2_ port.
REQ-013 mem_req_address  output  XLEN  address to the L2/memory.
REQ-014 mem_req_type  output  memory_operation_e  operation type to the L2/memory.
REQ-015 mem_req_valid  output  1  request to the L2/memory is active.
REQ-016 mem_word_to_store  output  XLEN  store data to the L2/memory.
REQ-017 mem_fetched_word  input  XLEN  word returned by the L2/memory.
REQ-018 mem_req_fulfilled  input  1  L2/memory completion strobe.
REQ-019 ic_grant_count, dc_grant_count  output  CNT_WIDTH  number of grants issued per client.

Function
REQ-020 SHALL implement an FSM with states IDLE, SERVE_IC, SERVE_DC and RESPOND.
REQ-021 In IDLE with exactly one client valid, SHALL grant that client and enter SERVE_IC or SERVE_DC on the next edge.
REQ-022 In IDLE with both clients valid, SHALL grant the client not granted most recently (round-robin); the last_grant flag SHALL reset to "dc", so icache wins the first tie.
REQ-023 At grant, SHALL latch the winner's address, type and store word into internal registers.
REQ-024 mem_req_* outputs SHALL drive these latched values, not the live client inputs.
REQ-025 mem_req_valid SHALL be 1 exactly while in SERVE_IC or SERVE_DC, so first assertion is one cycle after the winning client's valid.
REQ-026 In SERVE_x, SHALL hold all mem_req_* outputs stable until mem_req_fulfilled=1, for any number of wait cycles.
REQ-027 On mem_req_fulfilled=1 in SERVE_x, SHALL capture mem_fetched_word into the granted client's fetched-word register and enter RESPOND.
REQ-028 In RESPOND, SHALL assert only the granted client's _req_fulfilled for exactly one cycle with mem_req_valid=0, then return to IDLE.
REQ-029 A request still valid on the IDLE cycle after RESPOND SHALL be treated as a new request.
REQ-030 ic_fetched_word and dc_fetched_word SHALL each hold their last captured value until the next completion for that client.
REQ-031 mem_req_fulfilled in IDLE or RESPOND SHALL be ignored.
REQ-032 A client deasserting valid while being served SHALL NOT abort the transaction; it completes normally.
REQ-033 Each grant SHALL increment the winner's grant counter by 1, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-034 ic_req_fulfilled and dc_req_fulfilled SHALL never be 1 in the same cycle.
REQ-035 At most one transaction SHALL be outstanding to the memory at any time.

Reset
REQ-036 On reset=1 at a clock edge, SHALL enter IDLE and clear: last_grant to "dc", all latched request registers, both fetched-word registers and both grant counters.
REQ-037 During and after reset, mem_req_valid, ic_req_fulfilled and dc_req_fulfilled SHALL be 0, and all data outputs SHALL be 0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction with no fulfilled pulse, and a late mem_req_fulfilled SHALL be ignored.

Verification
REQ-039 dc only: dc read 0x0000_1040, memory fulfills 3 cycles later with 0xDEADBEEF -> mem_req_address=0x0000_1040 held stable, then dc_req_fulfilled pulses 1 cycle, dc_fetched_word=0xDEADBEEF, dc_grant_count=1.
REQ-040 Simultaneous ic and dc valid after reset -> icache served first, then dcache, then with both still valid icache again (strict alternation); counters read 2/1 after three grants.
REQ-041 dc store 0x0000_0200 with data 0x1234_5678 -> mem_word_to_store=0x1234_5678 and mem_req_type=store for the whole SERVE_DC duration; ic_req_fulfilled stays 0.
REQ-042 Reset pulsed during SERVE_IC, then mem_req_fulfilled=1 -> no fulfilled pulse, state IDLE, counters 0.
REQ-043 With CNT_WIDTH=2, five dc grants -> dc_grant_count saturates at 3.
REQ-044 dc drops valid mid-SERVE_DC -> transaction still completes and dc_req_fulfilled pulses once.
